// File: rtl/fp_add_pkg.sv
// Shared types, constants and field helpers for the single-precision add/sub sequencer.
package fp_add_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_UNPACK = 3'd1,
    S_ALIGN  = 3'd2,
    S_ADD    = 3'd3,
    S_NORM   = 3'd4,
    S_ROUND  = 3'd5,
    S_DONE   = 3'd6
  } state_e;

  localparam logic [7:0]  EXP_MAX = 8'hFF;
  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam int          MANT_W  = 24;
  localparam int          GRS_W   = 3;

  function automatic logic f_sign(input logic [31:0] v);
    return v[31];
  endfunction

  function automatic logic [7:0] f_exp(input logic [31:0] v);
    return v[30:23];
  endfunction

  // Denormals carry no mantissa: a zero exponent means the operand is zero.
  function automatic logic [MANT_W-1:0] f_mant(input logic [31:0] v);
    return (v[30:23] != 8'd0) ? {1'b1, v[22:0]} : 24'd0;
  endfunction

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even on a normalized mantissa with guard/round/sticky bits.
module fp_round_rne
  import fp_add_pkg::*;
(
  input  logic [23:0] mant_i,
  input  logic [7:0]  exp_i,
  input  logic        g_i,
  input  logic        r_i,
  input  logic        s_i,
  output logic [23:0] mant_o,
  output logic [7:0]  exp_o,
  output logic        overflow_o
);

  logic        inc_s;
  logic [24:0] sum_s;
  logic [8:0]  exp_s;

  // Increment on more-than-half or on an exact tie with an odd lsb; saturate to infinity
  always_comb begin
    inc_s = g_i & (r_i | s_i | mant_i[0]);
    sum_s = {1'b0, mant_i} + {24'd0, inc_s};
    if (sum_s[24]) begin
      mant_o = 24'h80_0000;
      exp_s  = {1'b0, exp_i} + 9'd1;
    end else begin
      mant_o = sum_s[23:0];
      exp_s  = {1'b0, exp_i};
    end
    if (exp_s >= {1'b0, EXP_MAX}) begin
      overflow_o = 1'b1;
      exp_o      = EXP_MAX;
      mant_o     = 24'd0;
    end else begin
      overflow_o = 1'b0;
      exp_o      = exp_s[7:0];
    end
  end

endmodule

// File: rtl/fp_add_sequencer.sv
// Multi-cycle IEEE-754 single-precision adder/subtractor: one FSM state per step,
// alignment and normalization move one bit per cycle.
module fp_add_sequencer
  import fp_add_pkg::*;
#(
  parameter int ALIGN_LIMIT  = 26,
  parameter int FLUSH_DENORM = 1
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        start,
  input  logic        op_sub,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        ready,
  output logic        valid,
  output logic [31:0] result,
  output logic        overflow,
  output logic        zero,
  output logic        invalid
);

  state_e      state_q;
  logic [31:0] a_q, b_q;
  logic        op_q;
  logic        sx_q, sy_q;
  logic [9:0]  ex_q;
  logic [7:0]  diff_q;
  logic [23:0] mx_q, my_q;
  logic        g_q, r_q, s_q;
  logic [27:0] acc_q;   // {carry, mantissa[23:0], G, R, S}
  logic        ready_q, valid_q, overflow_q, zero_q, invalid_q;
  logic [31:0] result_q;

  logic        sa_s, sb_s;
  logic [31:0] ka_s, kb_s;
  logic        sx_d, sy_d, special_d;
  logic [7:0]  ex_d, ey_d, diff_d;
  logic [23:0] mx_d, my_d;

  logic [23:0] rnd_mant_s;
  logic [7:0]  rnd_exp_s;
  logic        rnd_ovf_s;

  // Order the latched operands so X has the larger magnitude and detect NaN/Inf inputs
  always_comb begin
    sa_s = f_sign(a_q);
    sb_s = f_sign(b_q) ^ op_q;
    ka_s = {f_exp(a_q), f_mant(a_q)};
    kb_s = {f_exp(b_q), f_mant(b_q)};
    if (kb_s > ka_s) begin
      sx_d = sb_s;        sy_d = sa_s;
      ex_d = f_exp(b_q);  ey_d = f_exp(a_q);
      mx_d = f_mant(b_q); my_d = f_mant(a_q);
    end else begin
      sx_d = sa_s;        sy_d = sb_s;
      ex_d = f_exp(a_q);  ey_d = f_exp(b_q);
      mx_d = f_mant(a_q); my_d = f_mant(b_q);
    end
    diff_d    = ex_d - ey_d;
    special_d = (f_exp(a_q) == EXP_MAX) || (f_exp(b_q) == EXP_MAX);
  end

  fp_round_rne u_round (
    .mant_i     (acc_q[26:3]),
    .exp_i      (ex_q[7:0]),
    .g_i        (acc_q[2]),
    .r_i        (acc_q[1]),
    .s_i        (acc_q[0]),
    .mant_o     (rnd_mant_s),
    .exp_o      (rnd_exp_s),
    .overflow_o (rnd_ovf_s)
  );

  // Sequencer FSM with inline align/normalize shifters and registered outputs
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= S_IDLE;
      a_q        <= 32'd0;
      b_q        <= 32'd0;
      op_q       <= 1'b0;
      sx_q       <= 1'b0;
      sy_q       <= 1'b0;
      ex_q       <= 10'd0;
      diff_q     <= 8'd0;
      mx_q       <= 24'd0;
      my_q       <= 24'd0;
      g_q        <= 1'b0;
      r_q        <= 1'b0;
      s_q        <= 1'b0;
      acc_q      <= 28'd0;
      ready_q    <= 1'b1;
      valid_q    <= 1'b0;
      result_q   <= 32'd0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
      invalid_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          valid_q <= 1'b0;
          if (start) begin
            a_q        <= A;
            b_q        <= B;
            op_q       <= op_sub;
            ready_q    <= 1'b0;
            overflow_q <= 1'b0;
            zero_q     <= 1'b0;
            invalid_q  <= 1'b0;
            state_q    <= S_UNPACK;
          end else begin
            ready_q <= 1'b1;
          end
        end
        S_UNPACK: begin
          sx_q   <= sx_d;
          sy_q   <= sy_d;
          ex_q   <= {2'b00, ex_d};
          mx_q   <= mx_d;
          diff_q <= diff_d;
          g_q    <= 1'b0;
          r_q    <= 1'b0;
          if (special_d) begin
            result_q  <= QNAN;
            invalid_q <= 1'b1;
            valid_q   <= 1'b1;
            state_q   <= S_DONE;
          end else if (diff_d == 8'd0) begin
            my_q    <= my_d;
            s_q     <= 1'b0;
            state_q <= S_ADD;
          end else if ({24'd0, diff_d} > ALIGN_LIMIT) begin
            // Far too small to reach the guard bit: keep only its presence as sticky
            my_q    <= 24'd0;
            s_q     <= (my_d != 24'd0);
            state_q <= S_ADD;
          end else begin
            my_q    <= my_d;
            s_q     <= 1'b0;
            state_q <= S_ALIGN;
          end
        end
        S_ALIGN: begin
          {my_q, g_q, r_q} <= {1'b0, my_q, g_q};
          s_q              <= r_q | s_q;
          diff_q           <= diff_q - 8'd1;
          if (diff_q == 8'd1) begin
            state_q <= S_ADD;
          end else begin
            state_q <= S_ALIGN;
          end
        end
        S_ADD: begin
          // Ordering guarantees X >= Y, so the difference never goes negative
          if (sx_q == sy_q) begin
            acc_q <= {1'b0, mx_q, 3'b000} + {1'b0, my_q, g_q, r_q, s_q};
          end else begin
            acc_q <= {1'b0, mx_q, 3'b000} - {1'b0, my_q, g_q, r_q, s_q};
          end
          state_q <= S_NORM;
        end
        S_NORM: begin
          if (acc_q[27]) begin
            acc_q   <= {1'b0, acc_q[27:2], acc_q[1] | acc_q[0]};
            ex_q    <= ex_q + 10'd1;
            state_q <= S_ROUND;
          end else if (acc_q == 28'd0) begin
            result_q <= {sx_q & sy_q, 31'd0};
            zero_q   <= 1'b1;
            valid_q  <= 1'b1;
            state_q  <= S_DONE;
          end else if (acc_q[26]) begin
            state_q <= S_ROUND;
          end else if ((FLUSH_DENORM != 0) && (ex_q <= 10'd1)) begin
            result_q <= {sx_q, 31'd0};
            zero_q   <= 1'b1;
            valid_q  <= 1'b1;
            state_q  <= S_DONE;
          end else begin
            acc_q <= {acc_q[26:0], 1'b0};
            ex_q  <= ex_q - 10'd1;
            if (acc_q[25]) begin
              state_q <= S_ROUND;
            end else begin
              state_q <= S_NORM;
            end
          end
        end
        S_ROUND: begin
          result_q   <= {sx_q, rnd_exp_s, rnd_mant_s[22:0]};
          overflow_q <= rnd_ovf_s;
          valid_q    <= 1'b1;
          state_q    <= S_DONE;
        end
        S_DONE: begin
          valid_q <= 1'b0;
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
        default: begin
          valid_q <= 1'b0;
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign ready    = ready_q;
  assign valid    = valid_q;
  assign result   = result_q;
  assign overflow = overflow_q;
  assign zero     = zero_q;
  assign invalid  = invalid_q;

endmodule

// File: tb/tb_fp_add_sequencer.sv
// Directed bench for fp_add_sequencer: hand-computed results, latencies and flags.
module tb_fp_add_sequencer;

  logic        Clk;
  logic        Reset_n;
  logic        start;
  logic        op_sub;
  logic [31:0] A;
  logic [31:0] B;
  logic        ready;
  logic        valid;
  logic [31:0] result;
  logic        overflow;
  logic        zero;
  logic        invalid;

  int checks;
  int fails;

  fp_add_sequencer dut (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .start    (start),
    .op_sub   (op_sub),
    .A        (A),
    .B        (B),
    .ready    (ready),
    .valid    (valid),
    .result   (result),
    .overflow (overflow),
    .zero     (zero),
    .invalid  (invalid)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // One request; exp_lat < 0 skips the latency check, pulse_at > 0 re-pulses start in that cycle.
  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic sub, input int exp_lat, input int pulse_at,
                       input logic [31:0] exp_res, input logic e_ovf,
                       input logic e_zero, input logic e_inv);
    int  cyc;
    int  rdy_high;
    bit  got;
    @(negedge Clk);
    A = a; B = b; op_sub = sub; start = 1'b1;
    @(posedge Clk);
    cyc = 0; got = 1'b0; rdy_high = 0;
    while (!got && cyc < 100) begin
      @(negedge Clk);
      cyc++;
      start = (cyc == pulse_at) ? 1'b1 : 1'b0;
      if (ready) rdy_high++;
      if (valid) got = 1'b1;
    end
    start = 1'b0;
    chk({tag, "_got_valid"}, {31'd0, got}, 32'd1);
    if (exp_lat >= 0) chk({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
    chk({tag, "_ready_low"}, 32'(rdy_high), 32'd0);
    chk({tag, "_result"}, result, exp_res);
    chk({tag, "_flags"}, {29'd0, overflow, zero, invalid}, {29'd0, e_ovf, e_zero, e_inv});
    @(negedge Clk);
    chk({tag, "_after"}, {30'd0, ready, valid}, 32'd2);
    chk({tag, "_held"}, result, exp_res);
  endtask

  initial begin
    int spurious;
    checks = 0; fails = 0;
    Reset_n = 1'b0; start = 1'b0; op_sub = 1'b0; A = 32'd0; B = 32'd0;
    repeat (3) @(negedge Clk);
    chk("reset_outputs", {26'd0, ready, valid, overflow, zero, invalid, 1'b0}, 32'h20);
    chk("reset_result", result, 32'd0);
    Reset_n = 1'b1;
    @(negedge Clk);

    // NaN/Inf input takes the short path
    do_op("inf_in", 32'h7F80_0000, 32'h3F80_0000, 1'b0, 2, 0, 32'h7FC0_0000, 1'b0, 1'b0, 1'b1);
    // 1+1 with carry normalize; flags from the previous result must be cleared
    do_op("one_plus_one", 32'h3F80_0000, 32'h3F80_0000, 1'b0, 5, 0, 32'h4000_0000, 1'b0, 1'b0, 1'b0);

    // 1-1 with a stray start in cycle 2 that must not be queued
    do_op("one_minus_one", 32'h3F80_0000, 32'h3F80_0000, 1'b1, -1, 2, 32'h0000_0000, 1'b0, 1'b1, 1'b0);
    spurious = 0;
    repeat (8) begin
      @(negedge Clk);
      if (valid) spurious++;
    end
    chk("no_second_valid", 32'(spurious), 32'd0);

    do_op("one_minus_075", 32'h3F80_0000, 32'h3F40_0000, 1'b1, 7, 0, 32'h3E80_0000, 1'b0, 1'b0, 1'b0);
    do_op("tie_even", 32'h3F80_0000, 32'h3380_0000, 1'b0, 29, 0, 32'h3F80_0000, 1'b0, 1'b0, 1'b0);
    do_op("tie_odd", 32'h3F80_0001, 32'h3380_0000, 1'b0, 29, 0, 32'h3F80_0002, 1'b0, 1'b0, 1'b0);
    do_op("collapse", 32'h3F80_0000, 32'h3080_0000, 1'b0, 5, 0, 32'h3F80_0000, 1'b0, 1'b0, 1'b0);
    do_op("overflow", 32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 5, 0, 32'h7F80_0000, 1'b1, 1'b0, 1'b0);
    // Swapped operands: 1-2 = -1
    do_op("neg_result", 32'h3F80_0000, 32'h4000_0000, 1'b1, 6, 0, 32'hBF80_0000, 1'b0, 1'b0, 1'b0);

    // Abort mid-operation with reset
    @(negedge Clk);
    A = 32'h3F80_0000; B = 32'h3F40_0000; op_sub = 1'b1; start = 1'b1;
    @(posedge Clk);
    @(negedge Clk); start = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    Reset_n = 1'b0;
    #1;
    chk("abort_outputs", {26'd0, ready, valid, overflow, zero, invalid, 1'b0}, 32'h20);
    chk("abort_result", result, 32'd0);
    @(negedge Clk);
    Reset_n = 1'b1;
    spurious = 0;
    repeat (10) begin
      @(negedge Clk);
      if (valid) spurious++;
    end
    chk("abort_no_valid", 32'(spurious), 32'd0);
    chk("abort_ready", {31'd0, ready}, 32'd1);
    do_op("after_abort", 32'h3F80_0000, 32'h3F80_0000, 1'b0, 5, 0, 32'h4000_0000, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
